// File: rtl/lockable_reg_pkg.sv
// Shared types and sizing helpers for the lockable configuration register bank.
package lockable_reg_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_KEY = 16'hA5C3;

    // Counter wide enough to hold the value max_fails itself.
    function automatic int fail_cnt_w(input int max_fails);
        int w;
        w = $clog2(max_fails + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int addr_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/lockable_reg_bank_if.sv
// Access-path bundle between the debug/JTAG master and the protected register bank.
interface lockable_reg_bank_if
    import lockable_reg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 6,
    parameter int KEY_W    = 16
);
    localparam int ADDR_W = addr_w(NUM_REGS);

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                unlock_en;
    logic [KEY_W-1:0]    unlock_key;
    logic                relock;
    logic                lock_set;
    logic [NUM_REGS-1:0] lock_mask;
    logic                wr_ack;
    logic                wr_err;
    logic                unlocked;
    logic                lockout;
    logic [NUM_REGS-1:0] reg_lock;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, unlock_en, unlock_key,
               relock, lock_set, lock_mask,
        input  rd_data, wr_ack, wr_err, unlocked, lockout, reg_lock
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, unlock_en, unlock_key,
               relock, lock_set, lock_mask,
        output rd_data, wr_ack, wr_err, unlocked, lockout, reg_lock
    );

endinterface

// File: rtl/lockable_reg_bank_unlock_ctrl.sv
// Key-based unlock FSM with a consecutive-failure counter and terminal lockout.
module unlock_ctrl
    import lockable_reg_pkg::*;
#(
    parameter int               KEY_W      = 16,
    parameter logic [KEY_W-1:0] UNLOCK_KEY = DEFAULT_KEY,
    parameter int               MAX_FAILS  = 3
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             unlock_en,
    input  logic [KEY_W-1:0] unlock_key,
    input  logic             relock,
    output state_t           state_o
);
    localparam int             FCW     = fail_cnt_w(MAX_FAILS);
    localparam logic [FCW-1:0] MAX_CNT = FCW'(MAX_FAILS);

    state_t           state_q;
    logic [KEY_W-1:0] key_q;
    logic [FCW-1:0]   fail_q;
    logic [FCW-1:0]   fail_inc;

    assign fail_inc = fail_q + FCW'(1);
    assign state_o  = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCKED;
            key_q   <= '0;
            fail_q  <= '0;
        end else begin
            case (state_q)
                LOCKED: begin
                    if (unlock_en) begin
                        key_q   <= unlock_key;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (key_q == UNLOCK_KEY) begin
                        fail_q  <= '0;
                        state_q <= UNLOCKED;
                    end else begin
                        fail_q  <= fail_inc;
                        state_q <= (fail_inc == MAX_CNT) ? LOCKOUT : LOCKED;
                    end
                end
                UNLOCKED: begin
                    if (relock) state_q <= LOCKED;
                end
                LOCKOUT: state_q <= LOCKOUT;
                default: state_q <= LOCKED;
            endcase
        end
    end

endmodule

// File: rtl/lockable_reg_bank.sv
// Write-protected configuration register bank: data registers, sticky locks,
// write qualification and registered read path around the unlock FSM.
module lockable_reg_bank
    import lockable_reg_pkg::*;
#(
    parameter int                NUM_REGS   = 4,
    parameter int                DATA_W     = 6,
    parameter int                KEY_W      = 16,
    parameter logic [KEY_W-1:0]  UNLOCK_KEY = DEFAULT_KEY,
    parameter int                MAX_FAILS  = 3,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
)(
    input logic                clk,
    input logic                reset_n,
    lockable_reg_bank_if.slave bus
);
    localparam int ADDR_W = addr_w(NUM_REGS);

    // Reset asserts asynchronously but releases on a clock edge for the whole bank.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t state;

    unlock_ctrl #(
        .KEY_W      (KEY_W),
        .UNLOCK_KEY (UNLOCK_KEY),
        .MAX_FAILS  (MAX_FAILS)
    ) u_unlock_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .unlock_en  (bus.unlock_en),
        .unlock_key (bus.unlock_key),
        .relock     (bus.relock),
        .state_o    (state)
    );

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] reg_lock_q, reg_lock_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                wr_ack_q, wr_ack_d;
    logic                wr_err_q, wr_err_d;
    logic                wr_addr_ok, rd_addr_ok, wr_locked, wr_ok;

    assign wr_addr_ok = 32'(bus.wr_addr) < 32'(NUM_REGS);
    assign rd_addr_ok = 32'(bus.rd_addr) < 32'(NUM_REGS);

    // Decisions use registered state and locks, so same-cycle relock/lock_set do not block.
    always_comb begin
        wr_locked = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bus.wr_addr == ADDR_W'(i)) wr_locked = reg_lock_q[i];
        end
        wr_ok    = bus.wr_en && (state == UNLOCKED) && wr_addr_ok && !wr_locked;
        wr_ack_d = wr_ok;
        wr_err_d = bus.wr_en && !wr_ok;

        reg_lock_d = reg_lock_q;
        if (bus.lock_set && (state != LOCKOUT)) reg_lock_d = reg_lock_q | bus.lock_mask;

        rd_data_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_ok && (bus.rd_addr == ADDR_W'(i))) rd_data_d = regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            reg_lock_q <= '0;
            rd_data_q  <= RESET_VAL;
            wr_ack_q   <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (bus.wr_addr == ADDR_W'(i))) regs_q[i] <= bus.wr_data;
            end
            reg_lock_q <= reg_lock_d;
            rd_data_q  <= rd_data_d;
            wr_ack_q   <= wr_ack_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.wr_ack   = wr_ack_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.reg_lock = reg_lock_q;
    assign bus.unlocked = (state == UNLOCKED);
    assign bus.lockout  = (state == LOCKOUT);

endmodule
